// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined immediate generator for the RV32/RV64 decode path. The immediate
//   of the incoming instruction word is extracted and extended combinationally
//   at the input. It then travels through STAGES register stages with a
//   valid/ready handshake, together with an opaque tag and an error flag.
//
// Parameters
//   XLEN    output width, 32 or 64
//   STAGES  number of register stages, 1..3
//   TAG_W   width of the passthrough tag
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset; empties the pipe, zeroes outputs
//   flush      synchronous kill of every in-flight entry; no input captured
//   in_valid   instr / imm_src / in_tag are valid
//   in_ready   stage 1 can accept this cycle (independent of in_valid)
//   instr      instruction word, bits [6:0] ignored
//   imm_src    000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT, 110 ZIMM, 111 bad
//   in_tag     tag accompanying the instruction
//   out_valid  imm_ext / out_tag / imm_err are valid
//   out_ready  consumer accepts the output
//   imm_ext    extended immediate
//   out_tag    tag of the entry at the output
//   imm_err    the entry had imm_src = 111
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_J     = 3'b011;
    localparam logic [2:0] SRC_U     = 3'b100;
    localparam logic [2:0] SRC_SHAMT = 3'b101;
    localparam logic [2:0] SRC_ZIMM  = 3'b110;

    // ------------------------------------------------------------------
    // Input-side extraction. Every format is first built as a 32-bit value;
    // the sign-extending formats then replicate bit 31 up to XLEN.
    // ------------------------------------------------------------------
    logic [31:0]     imm32;
    logic            sext;
    logic            err_in;
    logic [XLEN-1:0] imm_in;
    logic            unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        imm32  = '0;
        sext   = 1'b1;
        err_in = 1'b0;
        case (imm_src)
            SRC_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
            SRC_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SRC_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            SRC_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            SRC_U:     imm32 = {instr[31:12], 12'b0};
            SRC_SHAMT: begin
                // RV64 shift amounts carry one extra bit (instr[25]).
                sext  = 1'b0;
                imm32 = {26'b0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
            end
            SRC_ZIMM: begin
                sext  = 1'b0;
                imm32 = {27'b0, instr[19:15]};
            end
            default:   err_in = 1'b1;  // reserved code: value stays 0
        endcase
        imm_in        = {XLEN{sext & imm32[31]}};
        imm_in[31:0]  = imm32;
    end

    // ------------------------------------------------------------------
    // Pipeline. Stage index 0 is the first stage, STAGES-1 drives outputs.
    // The chain_* vectors prepend the input so stage k always takes its
    // upstream from chain index k.
    // ------------------------------------------------------------------
    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0]             valid_d;
    logic [STAGES-1:0]             accept;
    logic [STAGES-1:0]             load;
    logic [STAGES-1:0][XLEN-1:0]   imm_q;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q;
    logic [STAGES-1:0]             err_q;

    logic [STAGES:0]               chain_valid;
    logic [STAGES:0][XLEN-1:0]     chain_imm;
    logic [STAGES:0][TAG_W-1:0]    chain_tag;
    logic [STAGES:0]               chain_err;

    assign chain_valid = {valid_q, in_valid};
    assign chain_imm   = {imm_q, imm_in};
    assign chain_tag   = {tag_q, in_tag};
    assign chain_err   = {err_q, err_in};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Unrolled form of "empty, or the next stage accepts": a stage can
        // move unless it and every stage after it are full and the consumer
        // is stalling. This is what lets bubbles collapse.
        assign accept[k]  = out_ready | ~(&valid_q[STAGES-1:k]);
        assign load[k]    = accept[k] & chain_valid[k];
        assign valid_d[k] = accept[k] ? chain_valid[k] : valid_q[k];
    end

    // Reset beats flush beats normal advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (load[i]) begin
                imm_q[i] <= chain_imm[i];
                tag_q[i] <= chain_tag[i];
                err_q[i] <= chain_err[i];
            end
        end
        // NOTE: only the output stage's data is reset, because its value is
        // visible on the ports; inner stages are guarded by their valid bit.
        if (reset) begin
            imm_q[STAGES-1] <= '0;
            tag_q[STAGES-1] <= '0;
            err_q[STAGES-1] <= 1'b0;
        end
    end

    assign in_ready  = accept[0];
    assign out_valid = valid_q[STAGES-1];
    assign imm_ext   = imm_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign imm_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Three instances share the input bus and reset/flush:
//     index 0: XLEN=32, STAGES=1
//     index 1: XLEN=64, STAGES=2
//     index 2: XLEN=32, STAGES=3
//   Each task targets one instance; the others simply absorb the traffic.
//   Inputs change on the falling edge, outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            flush;
    logic            in_valid;
    logic [31:0]     instr;
    logic [2:0]      imm_src;
    logic [7:0]      in_tag;
    logic [2:0]      in_ready;
    logic [2:0]      out_valid;
    logic [2:0]      out_ready;
    logic [2:0]      imm_err;
    logic [2:0][7:0] out_tag;
    logic [31:0]     imm_a;
    logic [63:0]     imm_b;
    logic [31:0]     imm_c;
    logic [63:0]     ext [3];

    int passed;
    int total;

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        logic [63:0] imm;
        logic        err;
    } vec_t;

    always_comb begin
        ext[0] = {32'h0, imm_a};
        ext[1] = imm_b;
        ext[2] = {32'h0, imm_c};
    end

    imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(8)) u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[0]),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .imm_ext(imm_a), .out_tag(out_tag[0]), .imm_err(imm_err[0])
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(8)) u_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[1]),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .imm_ext(imm_b), .out_tag(out_tag[1]), .imm_err(imm_err[1])
    );

    imm_gen_pipe #(.XLEN(32), .STAGES(3), .TAG_W(8)) u_c (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[2]),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .imm_ext(imm_c), .out_tag(out_tag[2]), .imm_err(imm_err[2])
    );

    // Reference: immediates as signed integers assembled from the format's
    // bit fields, then viewed at the instance's width.
    function automatic logic [63:0] model_imm(input logic [31:0] ins,
                                              input logic [2:0] src,
                                              input bit x64);
        longint v;
        case (src)
            3'd0: v = longint'($signed(ins[31:20]));
            3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd4: v = longint'($signed(ins[31:12])) * 4096;
            3'd5: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd6: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        return x64 ? 64'(v) : {32'h0, v[31:0]};
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = '1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        instr     = $urandom;
        imm_src   = 3'd7;
        in_tag    = 8'hFF;
        out_ready = '1;
        repeat (3) cycle();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (out_valid[d] !== 1'b0 || ext[d] !== 64'h0 || out_tag[d] !== 8'h0 || imm_err[d] !== 1'b0)
                $display("FAIL reset_state[%0d]: got v=%b imm=%h tag=%h err=%b want all zero",
                         d, out_valid[d], ext[d], out_tag[d], imm_err[d]);
            else passed++;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 3'b111) $display("FAIL reset_in_ready: got %b want 111", in_ready);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        vec_t v [7];
        v = '{
            '{32'hFFF00093, 3'd0, 64'h00000000FFFFFFFF, 1'b0},
            '{32'hFE112E23, 3'd1, 64'h00000000FFFFFFFC, 1'b0},
            '{32'h123450B7, 3'd4, 64'h0000000012345000, 1'b0},
            '{32'h001000EF, 3'd3, 64'h0000000000000800, 1'b0},
            '{32'hFE000EE3, 3'd2, 64'h00000000FFFFFFFC, 1'b0},
            '{32'h000F8073, 3'd6, 64'h000000000000001F, 1'b0},
            '{32'hFFFFFFFF, 3'd7, 64'h0000000000000000, 1'b1}
        };
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            instr    = v[i].ins;
            imm_src  = v[i].src;
            in_tag   = 8'(8'h10 + i);
            cycle();
            total++;
            if (out_valid[0] !== 1'b1 || ext[0] !== v[i].imm || out_tag[0] !== 8'(8'h10 + i) || imm_err[0] !== v[i].err)
                $display("FAIL basic32[%0d]: got v=%b imm=%h tag=%h err=%b want v=1 imm=%h tag=%h err=%b",
                         i, out_valid[0], ext[0], out_tag[0], imm_err[0], v[i].imm, 8'(8'h10 + i), v[i].err);
            else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_xlen64();
        vec_t v [3];
        v = '{
            '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0},
            '{32'h800000B7, 3'd4, 64'hFFFFFFFF80000000, 1'b0},
            '{32'h03F00013, 3'd5, 64'h000000000000003F, 1'b0}
        };
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            instr    = v[i].ins;
            imm_src  = v[i].src;
            in_tag   = 8'(8'h20 + i);
            cycle();
            in_valid = 1'b0;
            total++;
            if (out_valid[1] !== 1'b0) $display("FAIL xlen64_early[%0d]: got v=%b want 0", i, out_valid[1]);
            else passed++;
            cycle();
            total++;
            if (out_valid[1] !== 1'b1 || ext[1] !== v[i].imm || out_tag[1] !== 8'(8'h20 + i))
                $display("FAIL xlen64[%0d]: got v=%b imm=%h tag=%h want v=1 imm=%h tag=%h",
                         i, out_valid[1], ext[1], out_tag[1], v[i].imm, 8'(8'h20 + i));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        int   next_tag;
        int   got;
        int   gaps;
        do_reset();
        next_tag = 1;
        got      = 0;
        gaps     = 0;
        for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
            in_valid     = (next_tag <= 6);
            in_tag       = 8'(next_tag);
            instr        = $urandom;
            imm_src      = 3'($urandom_range(0, 7));
            out_ready    = '1;
            out_ready[2] = !(cyc >= 4 && cyc <= 8);
            #1;
            if (cyc >= 4 && cyc <= 8) begin
                total++;
                if (in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1 || out_tag[2] !== 8'd1)
                    $display("FAIL bp_hold[cyc %0d]: got in_ready=%b v=%b tag=%0d want 0,1,1",
                             cyc, in_ready[2], out_valid[2], out_tag[2]);
                else passed++;
            end
            if (cyc >= 9 && !out_valid[2]) gaps++;
            if (out_valid[2] && out_ready[2]) begin
                total++;
                got++;
                if (q.size() == 0) begin
                    $display("FAIL bp_extra: got tag %0d want nothing", out_tag[2]);
                end else begin
                    e = q.pop_front();
                    if (ext[2] !== e.imm || out_tag[2] !== e.tag || imm_err[2] !== e.err)
                        $display("FAIL bp_order: got imm=%h tag=%0d err=%b want imm=%h tag=%0d err=%b",
                                 ext[2], out_tag[2], imm_err[2], e.imm, e.tag, e.err);
                    else passed++;
                end
            end
            if (in_valid && in_ready[2]) begin
                e.imm = model_imm(instr, imm_src, 1'b0);
                e.tag = in_tag;
                e.err = (imm_src == 3'd7);
                q.push_back(e);
                next_tag++;
            end
            cycle();
        end
        in_valid = 1'b0;
        total++;
        if (got != 6 || gaps != 0 || q.size() != 0)
            $display("FAIL bp_complete: got count=%0d gaps=%0d left=%0d want 6,0,0", got, gaps, q.size());
        else passed++;
        repeat (3) begin
            total++;
            if (out_valid[2] !== 1'b0) $display("FAIL bp_dup: got v=%b tag=%0d want v=0", out_valid[2], out_tag[2]);
            else passed++;
            cycle();
        end
    endtask

    task automatic test_flush();
        logic [31:0] ins;
        logic [2:0]  src;
        do_reset();
        in_valid = 1'b1;
        instr    = $urandom;
        imm_src  = 3'd0;
        in_tag   = 8'hA1;
        cycle();
        in_tag   = 8'hA2;
        cycle();
        flush        = 1'b1;
        in_tag       = 8'hA3;
        out_ready[1] = 1'b0;
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = '1;
        #1;
        total++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1)
            $display("FAIL flush_clear: got v=%b in_ready=%b want 0,1", out_valid[1], in_ready[1]);
        else passed++;
        repeat (4) begin
            cycle();
            total++;
            if (out_valid[1] !== 1'b0) $display("FAIL flush_ghost: got v=%b tag=%h want v=0", out_valid[1], out_tag[1]);
            else passed++;
        end
        ins      = $urandom;
        src      = 3'd1;
        in_valid = 1'b1;
        instr    = ins;
        imm_src  = src;
        in_tag   = 8'hA4;
        cycle();
        in_valid = 1'b0;
        total++;
        if (out_valid[1] !== 1'b0) $display("FAIL flush_after_early: got v=%b want 0", out_valid[1]);
        else passed++;
        cycle();
        total++;
        if (out_valid[1] !== 1'b1 || out_tag[1] !== 8'hA4 || ext[1] !== model_imm(ins, src, 1'b1))
            $display("FAIL flush_after: got v=%b tag=%h imm=%h want v=1 tag=a4 imm=%h",
                     out_valid[1], out_tag[1], ext[1], model_imm(ins, src, 1'b1));
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] ins;
        do_reset();
        out_ready[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            instr    = 32'hFFF00093;
            imm_src  = 3'd7;
            in_tag   = 8'(8'h30 + i);
            cycle();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0)
            $display("FAIL mid_full: got v=%b in_ready=%b want 1,0", out_valid[2], in_ready[2]);
        else passed++;
        reset = 1'b1;
        cycle();
        total++;
        if (out_valid[2] !== 1'b0 || ext[2] !== 64'h0 || out_tag[2] !== 8'h0 || imm_err[2] !== 1'b0)
            $display("FAIL mid_reset: got v=%b imm=%h tag=%h err=%b want all zero",
                     out_valid[2], ext[2], out_tag[2], imm_err[2]);
        else passed++;
        reset     = 1'b0;
        out_ready = '1;
        #1;
        total++;
        if (in_ready[2] !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready[2]);
        else passed++;
        ins      = $urandom;
        in_valid = 1'b1;
        instr    = ins;
        imm_src  = 3'd3;
        in_tag   = 8'h5A;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        total++;
        if (out_valid[2] !== 1'b1 || out_tag[2] !== 8'h5A || ext[2] !== model_imm(ins, 3'd3, 1'b0))
            $display("FAIL mid_fresh: got v=%b tag=%h imm=%h want v=1 tag=5a imm=%h",
                     out_valid[2], out_tag[2], ext[2], model_imm(ins, 3'd3, 1'b0));
        else passed++;
    endtask

    task automatic test_random(input int d, input int n, input bit bp);
        exp_t        q[$];
        exp_t        e;
        int          sent;
        bit          hold;
        bit          x64;
        logic [63:0] h_imm;
        logic [7:0]  h_tag;
        logic        h_err;
        do_reset();
        x64  = (d == 1);
        sent = 0;
        hold = 1'b0;
        for (int cyc = 0; cyc < 20 * n && (sent < n || q.size() != 0); cyc++) begin
            in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            instr     = $urandom;
            imm_src   = 3'($urandom_range(0, 7));
            in_tag    = 8'($urandom);
            out_ready = '1;
            if (bp) out_ready[d] = ($urandom_range(0, 2) != 0);
            #1;
            if (hold) begin
                total++;
                if (out_valid[d] !== 1'b1 || ext[d] !== h_imm || out_tag[d] !== h_tag || imm_err[d] !== h_err)
                    $display("FAIL rand%0d_stable: got v=%b imm=%h tag=%h want v=1 imm=%h tag=%h",
                             d, out_valid[d], ext[d], out_tag[d], h_imm, h_tag);
                else passed++;
            end
            hold  = out_valid[d] && !out_ready[d];
            h_imm = ext[d];
            h_tag = out_tag[d];
            h_err = imm_err[d];
            if (out_valid[d] && out_ready[d]) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL rand%0d_extra: got tag %h want nothing", d, out_tag[d]);
                end else begin
                    e = q.pop_front();
                    if (ext[d] !== e.imm || out_tag[d] !== e.tag || imm_err[d] !== e.err)
                        $display("FAIL rand%0d_data: got imm=%h tag=%h err=%b want imm=%h tag=%h err=%b",
                                 d, ext[d], out_tag[d], imm_err[d], e.imm, e.tag, e.err);
                    else passed++;
                end
            end
            if (in_valid && in_ready[d]) begin
                e.imm = model_imm(instr, imm_src, x64);
                e.tag = in_tag;
                e.err = (imm_src == 3'd7);
                q.push_back(e);
                sent++;
            end
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = '1;
        total++;
        if (sent != n || q.size() != 0)
            $display("FAIL rand%0d_drain: got sent=%0d left=%0d want sent=%0d left=0", d, sent, q.size(), n);
        else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        passed = 0;
        total  = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_xlen64();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random(0, 60, 1'b0);
        test_random(1, 60, 1'b1);
        test_random(2, 80, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RV32/RV64 decode path.
- Extracts and sign- or zero-extends the immediate of an instruction word for formats I, S, B, U and J, plus the shift-amount and CSR-zimm fields.
- Registers the result through STAGES pipeline stages with valid/ready handshake, flush and a passthrough tag.
- Sits between fetch/decode and the ID/EX register and replaces the single-cycle combinational extender.

Parameters:
- XLEN, 32, output width; legal values 32 or 64. Sign extension fills to XLEN.
- STAGES, 1, number of register stages; legal values 1..3.
- TAG_W, 8, width of the opaque tag carried alongside each instruction, e.g. ROB index or rd.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  instr, imm_src and in_tag are valid.
- in_ready  out  1  block accepts the input this cycle.
- instr  in  32  instruction word. Bits [6:0] are ignored.
- imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT, 110 ZIMM, 111 reserved.
- in_tag  in  TAG_W  tag accompanying the instruction.
- out_valid  out  1  imm_ext, out_tag and imm_err are valid.
- out_ready  in  1  consumer accepts the output.
- imm_ext  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the entry at the output.
- imm_err  out  1  the entry had imm_src = 111.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high.
- Reset: all stage valid bits, out_valid, imm_ext, out_tag and imm_err are 0. in_ready reads 1 in the first cycle after reset deasserts.
- Extraction happens combinationally at the input, before stage 1. Let s = instr[31] replicated to XLEN.
  - I: s with instr[31:20].
  - S: s with {instr[31:25], instr[11:7]}.
  - B: s with {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: s with {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended to XLEN when XLEN = 64.
  - SHAMT: zero-extended instr[24:20] when XLEN = 32; zero-extended instr[25:20] when XLEN = 64.
  - ZIMM: zero-extended instr[19:15].
  - 111: imm_ext = 0 and imm_err = 1. This is never X.
- Pipeline: STAGES register stages, each holding {valid, imm, tag, err}. The last stage drives the outputs.
  - Stage k advances when it is empty or stage k+1 accepts. The last stage accepts when it is empty or out_ready = 1.
  - in_ready equals the accept condition of stage 1. It is combinational from out_ready and the valid bits, and never depends on in_valid.
  - Transfer at input: in_valid && in_ready. Transfer at output: out_valid && out_ready.
- Latency: exactly STAGES cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Backpressure: while out_ready = 0 and out_valid = 1, the outputs hold stable.
  - Bubbles collapse: a stalled output does not stall earlier stages that hold empty slots.
  - With all stages full, in_ready = 0 and no entry is lost or duplicated.
- Ordering: strictly in order. Every accepted entry is produced exactly once unless flushed.
- Flush: in the cycle flush = 1, no input is captured, whatever in_valid and in_ready are.
  - On the next edge every stage valid bit clears, so out_valid = 0 in the following cycle.
  - Data registers may retain stale values.
  - in_ready is 1 in the cycle after a flush.
- Precedence: reset over flush over normal operation.
- Simultaneous events: an output transfer and an input transfer in the same cycle with all stages full is legal and sustains full throughput.
- Reset mid-stream discards everything in flight. No handshake is required to recover.
- Data-path registers need no reset except where the reset values above require it.

Test Plan:
- XLEN = 32, STAGES = 1, out_ready = 1. Stream instr 0xFFF00093/I, 0xFE112E23/S, 0x123450B7/U, 0x001000EF/J. Expected imm_ext one cycle after each input: 0xFFFFFFFF, 0xFFFFFFFC, 0x12345000, 0x00000800, with out_tag matching in_tag.
- B-type. 0xFE000EE3 (beq x0,x0,-4) -> imm_ext = 0xFFFFFFFC. ZIMM with instr[19:15] = 31 -> 0x0000001F. imm_src = 111 -> imm_ext = 0 and imm_err = 1.
- XLEN = 64. 0xFFF00093/I -> 0xFFFFFFFFFFFFFFFF. 0x800000B7/U -> 0xFFFFFFFF80000000. SHAMT with instr[25:20] = 63 -> 0x3F.
- STAGES = 3, backpressure. Send tags 1..6 back-to-back and hold out_ready = 0 from cycle 4.
  - in_ready drops after 3 entries are held.
  - Outputs stay stable at tag 1.
  - Releasing out_ready delivers tags 1..6 in order with no gaps or duplicates.
- STAGES = 2, flush. With 2 entries in flight, assert flush together with in_valid = 1 for 1 cycle.
  - Next cycle out_valid = 0 and the flush-cycle input is never emitted.
  - A subsequent input appears 2 cycles after acceptance.
- Reset mid-stream. Assert reset with 3 entries in flight.
  - Next cycle out_valid = 0, imm_ext = 0, out_tag = 0, imm_err = 0.
  - After reset deasserts, in_ready = 1 and fresh traffic is processed normally.
